// File: rtl/fetch_decode_link_pkg.sv
// Constants and helpers shared by the fetch unit, the D-stage controller
// and the IF/ID link: reset values, NPC select encodings, branch offset.
package fetch_decode_link_pkg;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  // Word offset of a branch immediate, already scaled to bytes.
  function automatic logic signed [DATA_W-1:0] br_offset(input logic [15:0] imm);
    logic signed [DATA_W-1:0] off;
    off = {{(DATA_W-18){imm[15]}}, imm, 2'b00};
    return off;
  endfunction

endpackage

// File: rtl/fetch_decode_link_npc_calc.sv
// Combinational next-PC mux. Redirect targets are formed from the D-stage
// PC, so the F-stage instruction behind a control op is its delay slot.
module npc_calc
  import fetch_decode_link_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] d_pc,
  input  logic [25:0]       d_target,
  input  logic [DATA_W-1:0] rs_val,
  output logic [DATA_W-1:0] npc
);

  logic signed [DATA_W-1:0] br_off;
  logic        [DATA_W-1:0] seq_pc;
  logic        [DATA_W-1:0] br_pc;
  logic        [DATA_W-1:0] j_pc;

  assign br_off = br_offset(d_target[15:0]);
  assign seq_pc = pc + 32'd4;
  assign br_pc  = d_pc + 32'd4 + $unsigned(br_off);
  assign j_pc   = {d_pc[31:28], d_target, 2'b00};

  always_comb begin
    npc = seq_pc;
    case (sel)
      NPC_SEQ: npc = seq_pc;
      NPC_BR:  npc = br_pc;
      NPC_J:   npc = j_pc;
      NPC_JR:  npc = rs_val;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_decode_link.sv
// IF/ID pipeline register on the consumer side of the fetch interface, the
// NPC return path, and fetch/stall performance counters.
module fetch_decode_link
  import fetch_decode_link_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = fetch_decode_link_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_decode_link_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [31:0] PC,
  input  logic [31:0] instr,
  input  logic [1:0]  D_npc_sel,
  input  logic [31:0] D_rs_val,
  output logic [31:0] NPC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] instr_p1;
  logic [31:0]       fetch_cnt_q;
  logic [31:0]       stall_cnt_q;

  // F -> D boundary: freezes together with the fetch unit's PC on Stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p1    <= RESET_PC;
      instr_p1 <= NOP_INSTR;
    end else if (!Stall) begin
      pc_p1    <= PC;
      instr_p1 <= instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (Stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  npc_calc u_npc_calc (
    .sel      (D_npc_sel),
    .pc       (PC),
    .d_pc     (pc_p1),
    .d_target (instr_p1[25:0]),
    .rs_val   (D_rs_val),
    .npc      (NPC)
  );

  assign D_PC      = pc_p1;
  assign D_instr   = instr_p1;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_decode_link.sv
// Randomized and directed bench for fetch_decode_link against a
// behavioural model of the IF/ID register, counters and NPC rules.
module tb_fetch_decode_link;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] instr;
  logic [1:0]  D_npc_sel;
  logic [31:0] D_rs_val;
  logic [31:0] NPC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_fc;
  logic [31:0] m_sc;

  always #5 clk = ~clk;

  fetch_decode_link dut (
    .clk       (clk),
    .reset     (reset),
    .Stall     (Stall),
    .PC        (PC),
    .instr     (instr),
    .D_npc_sel (D_npc_sel),
    .D_rs_val  (D_rs_val),
    .NPC       (NPC),
    .D_PC      (D_PC),
    .D_instr   (D_instr),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [1:0] sel, input logic [31:0] p,
                                            input logic [31:0] rs);
    logic signed [31:0] off;
    off = $signed(m_instr[15:0]);
    case (sel)
      2'd0:    return p + 32'd4;
      2'd1:    return m_pc + 32'd4 + $unsigned(off * 4);
      2'd2:    return (m_pc & 32'hF000_0000) | ({6'b0, m_instr[25:0]} << 2);
      default: return rs;
    endcase
  endfunction

  // One clock: drive at the falling edge, check NPC, clock, check state.
  task automatic cycle(input logic r, input logic s, input logic [31:0] p,
                       input logic [31:0] i, input logic [1:0] sel, input logic [31:0] rs);
    reset = r; Stall = s; PC = p; instr = i; D_npc_sel = sel; D_rs_val = rs;
    #1;
    chk("npc", NPC, model_npc(sel, p, rs));
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0000_3000; m_instr = 32'h0; m_fc = 32'h0; m_sc = 32'h0;
    end else if (!s) begin
      m_pc = p; m_instr = i; m_fc = m_fc + 32'd1;
    end else begin
      m_sc = m_sc + 32'd1;
    end
    @(negedge clk);
    chk("d_pc", D_PC, m_pc);
    chk("d_instr", D_instr, m_instr);
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("stall_cnt", stall_cnt, m_sc);
  endtask

  initial begin
    logic [31:0] fc_before;
    m_pc = 32'h0; m_instr = 32'h0; m_fc = 32'h0; m_sc = 32'h0;

    // Reset and reset values
    cycle(1'b1, 1'b0, 32'h3000, 32'h1234_5678, 2'd0, 32'h0);
    cycle(1'b1, 1'b1, 32'h3000, 32'h1234_5678, 2'd0, 32'h0);
    chk("rst_d_pc", D_PC, 32'h0000_3000);
    chk("rst_d_instr", D_instr, 32'h0);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);

    // Three unstalled fetches
    cycle(1'b0, 1'b0, 32'h3000, 32'h2401_0001, 2'd0, 32'h0);
    cycle(1'b0, 1'b0, 32'h3004, 32'h2402_0002, 2'd0, 32'h0);
    cycle(1'b0, 1'b0, 32'h3008, 32'h2403_0003, 2'd0, 32'h0);
    chk("seq_d_pc", D_PC, 32'h3008);
    chk("seq_fetch_cnt", fetch_cnt, 32'd3);

    // Backward and forward branch targets
    cycle(1'b0, 1'b0, 32'h3010, 32'h1000_FFFE, 2'd0, 32'h0);
    PC = 32'h3014; D_npc_sel = 2'd1; #1;
    chk("br_back", NPC, 32'h300C);
    cycle(1'b0, 1'b0, 32'h3010, 32'h1000_0003, 2'd1, 32'h0);
    PC = 32'h3014; D_npc_sel = 2'd1; #1;
    chk("br_fwd", NPC, 32'h3020);

    // j and jr targets
    cycle(1'b0, 1'b0, 32'h3000, 32'h0800_0C10, 2'd1, 32'h0);
    PC = 32'h3004; D_npc_sel = 2'd2; #1;
    chk("j_target", NPC, 32'h0000_3040);
    D_npc_sel = 2'd3; D_rs_val = 32'h3100; #1;
    chk("jr_target", NPC, 32'h3100);

    // Four-cycle stall mid-stream, then release loads the held PC
    cycle(1'b0, 1'b0, 32'h3020, 32'h0000_0020, 2'd0, 32'h0);
    fc_before = fetch_cnt;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 32'h3024, 32'hAAAA_0024, 2'd0, 32'h0);
    chk("stall_hold_pc", D_PC, 32'h3020);
    chk("stall_cnt4", stall_cnt, 32'd4);
    chk("stall_fc_frozen", fetch_cnt, fc_before);
    cycle(1'b0, 1'b0, 32'h3024, 32'hAAAA_0024, 2'd0, 32'h0);
    chk("release_pc", D_PC, 32'h3024);

    // Reset with Stall while D holds 0x3024
    cycle(1'b1, 1'b1, 32'h3028, 32'hBBBB_0028, 2'd0, 32'h0);
    chk("rst_stall_pc", D_PC, 32'h3000);
    chk("rst_stall_instr", D_instr, 32'h0);
    chk("rst_stall_sc", stall_cnt, 32'h0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), $urandom,
            $urandom, 2'($urandom_range(0, 3)), $urandom);
    end

    // Counter wrap
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    m_fc = 32'hFFFF_FFFF;
    cycle(1'b0, 1'b0, 32'h3010, 32'h1000_0003, 2'd0, 32'h0);
    chk("fc_wrap", fetch_cnt, 32'h0);

    // Branch in D, delay slot in F: slot enters D while NPC is the target
    PC = 32'h3014; D_npc_sel = 2'd1; #1;
    chk("slot_npc", NPC, 32'h3020);
    cycle(1'b0, 1'b0, 32'h3014, 32'h2408_0007, 2'd1, 32'h0);
    chk("slot_d_pc", D_PC, 32'h3014);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
